// File: rtl/snn_apb_csr.sv
// snn_apb_csr: APB slave CSR block for the SNN core.
// Decodes APB transfers into core configuration (enable, threshold, leak).
// Exposes status, a saturating spike counter and a sticky interrupt.
// Completion is delayed by WAIT_STATES access cycles with pready low.
// Optional: define SNN_APB_PSLVERR_EN to add the pslverr output.
//
// state | meaning
// IDLE  | no transfer; waiting for an APB setup phase
// WAIT  | access phase, pready low, counting down wait states
// DONE  | pready high for one cycle; a write commits on the closing edge
module snn_apb_csr #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 0,
    parameter int          CNT_W       = 32,
    parameter logic [15:0] THRESH_RST  = 16'h0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
`ifdef SNN_APB_PSLVERR_EN
    output logic              pslverr,
`endif
    output logic              snn_enable,
    output logic              snn_soft_clr,
    output logic [15:0]       snn_threshold,
    output logic [7:0]        snn_leak,
    input  logic              snn_busy,
    input  logic              spike_in,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_THRESH  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_LEAK    = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_SPIKE   = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_IRQ_CLR = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_LIMIT   = ADDR_W'(8'h18);

    // Loaded on entry to WAIT; a zero-wait build never enters WAIT.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t            state_q;
    logic [3:0]        wait_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic              pready_q;
    logic [31:0]       prdata_q;

    logic              ctrl_en_q;
    logic              ctrl_ie_q;
    logic [15:0]       thresh_q;
    logic [7:0]        leak_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  limit_q;
    logic              irq_pend_q;
    logic              soft_clr_q;

    logic              commit;
    logic              irq_set;
    logic              irq_clr;

    // Read data mux; the caller chooses the live or latched address so a
    // zero-wait read can load prdata on the same edge that latches paddr.
    function automatic logic [31:0] rd_mux(input logic [ADDR_W-1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            A_CTRL:   r = {29'b0, ctrl_ie_q, 1'b0, ctrl_en_q};
            A_THRESH: r = {16'b0, thresh_q};
            A_LEAK:   r = {24'b0, leak_q};
            A_STATUS: r = {30'b0, irq_pend_q, snn_busy};
            A_SPIKE:  r = 32'(cnt_q);
            A_LIMIT:  r = 32'(limit_q);
            default:  r = '0;
        endcase
        return r;
    endfunction

`ifdef SNN_APB_PSLVERR_EN
    logic pslverr_q;

    // Unmapped address, or a write aimed at a read-only register.
    function automatic logic is_err(input logic [ADDR_W-1:0] a, input logic w);
        logic mapped;
        mapped = (a == A_CTRL) || (a == A_THRESH) || (a == A_LEAK) ||
                 (a == A_STATUS) || (a == A_SPIKE) || (a == A_IRQ_CLR) ||
                 (a == A_LIMIT);
        return !mapped || (w && ((a == A_STATUS) || (a == A_SPIKE)));
    endfunction

    assign pslverr = pslverr_q;
`endif

    assign commit  = (state_q == DONE) && wr_q;
    assign irq_set = (limit_q != '0) && (cnt_q >= limit_q);
    assign irq_clr = commit && (addr_q == A_IRQ_CLR) && wdata_q[0];

    // Transfer FSM with registered pready/prdata (and pslverr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
`ifdef SNN_APB_PSLVERR_EN
            pslverr_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    pready_q <= 1'b0;
                    prdata_q <= '0;
`ifdef SNN_APB_PSLVERR_EN
                    pslverr_q <= 1'b0;
`endif
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        wr_q    <= pwrite;
                        wdata_q <= pwdata;
                        if (WAIT_STATES == 0) begin
                            state_q  <= DONE;
                            pready_q <= 1'b1;
                            prdata_q <= pwrite ? 32'h0 : rd_mux(paddr);
`ifdef SNN_APB_PSLVERR_EN
                            pslverr_q <= is_err(paddr, pwrite);
`endif
                        end else begin
                            state_q    <= WAIT;
                            wait_cnt_q <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (wait_cnt_q == 4'd0) begin
                        state_q  <= DONE;
                        pready_q <= 1'b1;
                        prdata_q <= wr_q ? 32'h0 : rd_mux(addr_q);
`ifdef SNN_APB_PSLVERR_EN
                        pslverr_q <= is_err(addr_q, wr_q);
`endif
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    pready_q <= 1'b0;
                    prdata_q <= '0;
`ifdef SNN_APB_PSLVERR_EN
                    pslverr_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Configuration registers, write commit and soft-clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q  <= 1'b0;
            ctrl_ie_q  <= 1'b0;
            thresh_q   <= THRESH_RST;
            leak_q     <= 8'h01;
            limit_q    <= '0;
            soft_clr_q <= 1'b0;
        end else begin
            soft_clr_q <= commit && (addr_q == A_CTRL) && wdata_q[1];
            if (commit) begin
                case (addr_q)
                    A_CTRL: begin
                        ctrl_en_q <= wdata_q[0];
                        ctrl_ie_q <= wdata_q[2];
                    end
                    A_THRESH: thresh_q <= wdata_q[15:0];
                    A_LEAK:   leak_q   <= wdata_q[7:0];
                    A_LIMIT:  limit_q  <= wdata_q[CNT_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

    // Saturating spike counter; the soft-clear pulse beats a same-cycle spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (soft_clr_q) begin
            cnt_q <= '0;
        end else if (spike_in && ctrl_en_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky interrupt; a set condition overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pend_q <= 1'b0;
        end else if (irq_set) begin
            irq_pend_q <= 1'b1;
        end else if (irq_clr) begin
            irq_pend_q <= 1'b0;
        end
    end

    assign pready        = pready_q;
    assign prdata        = prdata_q;
    assign snn_enable    = ctrl_en_q;
    assign snn_soft_clr  = soft_clr_q;
    assign snn_threshold = thresh_q;
    assign snn_leak      = leak_q;
    assign irq           = irq_pend_q & ctrl_ie_q;

endmodule

// File: tb/tb_snn_apb_csr.sv
// Directed bench for snn_apb_csr. Three instances share the APB bus
// (separate psel): u0 zero wait states, u1 three wait states, u2 a
// 4-bit spike counter.
module tb_snn_apb_csr;

    logic        clk;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        snn_busy;
    logic        spike_in;

    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  snn_enable;
    logic [2:0]  snn_soft_clr;
    logic [15:0] snn_threshold [3];
    logic [7:0]  snn_leak [3];
    logic [2:0]  irq;
`ifdef SNN_APB_PSLVERR_EN
    logic [2:0]  pslverr;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snn_apb_csr #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata[0]), .pready(pready[0]),
`ifdef SNN_APB_PSLVERR_EN
        .pslverr(pslverr[0]),
`endif
        .snn_enable(snn_enable[0]), .snn_soft_clr(snn_soft_clr[0]),
        .snn_threshold(snn_threshold[0]), .snn_leak(snn_leak[0]),
        .snn_busy(snn_busy), .spike_in(spike_in), .irq(irq[0]));

    snn_apb_csr #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata[1]), .pready(pready[1]),
`ifdef SNN_APB_PSLVERR_EN
        .pslverr(pslverr[1]),
`endif
        .snn_enable(snn_enable[1]), .snn_soft_clr(snn_soft_clr[1]),
        .snn_threshold(snn_threshold[1]), .snn_leak(snn_leak[1]),
        .snn_busy(snn_busy), .spike_in(spike_in), .irq(irq[1]));

    snn_apb_csr #(.WAIT_STATES(0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata[2]), .pready(pready[2]),
`ifdef SNN_APB_PSLVERR_EN
        .pslverr(pslverr[2]),
`endif
        .snn_enable(snn_enable[2]), .snn_soft_clr(snn_soft_clr[2]),
        .snn_threshold(snn_threshold[2]), .snn_leak(snn_leak[2]),
        .snn_busy(snn_busy), .spike_in(spike_in), .irq(irq[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One APB transfer on instance d; returns read data, access cycles with
    // pready low, and the error flag seen at completion.
    task automatic apb(input int d, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int nw, output bit err);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        nw = 0;
        while (!pready[d] && nw < 40) begin
            @(posedge clk); #1;
            nw++;
        end
        chk("pready_seen", {31'b0, pready[d]}, 32'h1);
        rd  = prdata[d];
        err = 1'b0;
`ifdef SNN_APB_PSLVERR_EN
        err = pslverr[d];
`endif
        @(posedge clk); #1;
        psel[d] = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", {31'b0, pready[d]}, 32'h0);
    endtask

    task automatic wr_reg(input int d, input logic [7:0] a, input logic [31:0] wd,
                          input bit exp_err);
        logic [31:0] rd;
        int          nw;
        bit          err;
        apb(d, 1'b1, a, wd, rd, nw, err);
`ifdef SNN_APB_PSLVERR_EN
        chk("wr_pslverr", {31'b0, err}, {31'b0, exp_err});
`else
        if (exp_err) chk("wr_no_pslverr", {31'b0, err}, 32'h0);
`endif
    endtask

    task automatic rd_reg(input int d, input logic [7:0] a, input logic [31:0] exp,
                          input string tag, input bit exp_err);
        logic [31:0] rd;
        int          nw;
        bit          err;
        apb(d, 1'b0, a, 32'h0, rd, nw, err);
        chk(tag, rd, exp);
`ifdef SNN_APB_PSLVERR_EN
        chk("rd_pslverr", {31'b0, err}, {31'b0, exp_err});
`else
        if (exp_err) chk("rd_no_pslverr", {31'b0, err}, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] rd;
        int          nw;
        bit          err;

        rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; snn_busy = 1'b0; spike_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", {31'b0, pready[0]}, 32'h0);
        chk("rst_prdata", prdata[0], 32'h0);
        rst_n = 1'b1;

        // Reset values
        rd_reg(0, 8'h00, 32'h0000_0000, "rst_ctrl", 1'b0);
        rd_reg(0, 8'h04, 32'h0000_0100, "rst_thresh", 1'b0);
        rd_reg(0, 8'h08, 32'h0000_0001, "rst_leak", 1'b0);
        rd_reg(0, 8'h0C, 32'h0000_0000, "rst_status", 1'b0);
        rd_reg(0, 8'h10, 32'h0000_0000, "rst_spike", 1'b0);
        rd_reg(0, 8'h18, 32'h0000_0000, "rst_limit", 1'b0);
        chk("rst_irq", {31'b0, irq[0]}, 32'h0);
        chk("rst_thresh_out", {16'b0, snn_threshold[0]}, 32'h0000_0100);

        // Zero wait states: pready in the first access cycle
        apb(0, 1'b1, 8'h04, 32'h0000_1234, rd, nw, err);
        chk("ws0_wait_cycles", nw, 0);
        chk("ws0_thresh_out", {16'b0, snn_threshold[0]}, 32'h0000_1234);
        chk("ws0_prdata_idle", prdata[0], 32'h0);
        rd_reg(0, 8'h04, 32'h0000_1234, "ws0_thresh_rd", 1'b0);
        wr_reg(0, 8'h08, 32'hFFFF_FF5A, 1'b0);
        chk("leak_out", {24'b0, snn_leak[0]}, 32'h0000_005A);
        rd_reg(0, 8'h08, 32'h0000_005A, "leak_rd", 1'b0);

        // Three wait states
        apb(1, 1'b0, 8'h08, 32'h0, rd, nw, err);
        chk("ws3_wait_cycles", nw, 3);
        chk("ws3_leak_rd", rd, 32'h0000_0001);

        // psel dropped mid-WAIT: no completion, no commit
        @(posedge clk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h0000_BEEF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (pready[1]) seen++;
            end
            chk("abort_no_pready", seen, 0);
        end
        chk("abort_thresh_out", {16'b0, snn_threshold[1]}, 32'h0000_0100);
        rd_reg(1, 8'h04, 32'h0000_0100, "abort_thresh_rd", 1'b0);

        // penable without a setup phase is ignored
        @(posedge clk); #1;
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h04;
        begin
            int seen;
            seen = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (pready[0]) seen++;
            end
            chk("no_setup_no_pready", seen, 0);
        end
        psel[0] = 1'b0; penable = 1'b0;

        // Unmapped read, read-only write
        rd_reg(0, 8'h3C, 32'h0, "unmapped_rd", 1'b1);
        wr_reg(0, 8'h10, 32'h0000_0055, 1'b1);
        rd_reg(0, 8'h10, 32'h0, "ro_spike_unchanged", 1'b0);
        rd_reg(0, 8'h14, 32'h0, "irq_clr_reads0", 1'b0);

        // Spike counting and interrupt
        wr_reg(0, 8'h18, 32'd10, 1'b0);
        wr_reg(0, 8'h00, 32'h0000_0005, 1'b0);
        chk("enable_out", {31'b0, snn_enable[0]}, 32'h1);
        rd_reg(0, 8'h00, 32'h0000_0005, "ctrl_rd", 1'b0);
        chk("irq_before", {31'b0, irq[0]}, 32'h0);
        @(posedge clk); #1;
        spike_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        spike_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("irq_at_limit", {31'b0, irq[0]}, 32'h1);
        rd_reg(0, 8'h10, 32'd10, "spike_cnt_10", 1'b0);
        snn_busy = 1'b1;
        rd_reg(0, 8'h0C, 32'h0000_0003, "status_busy_irq", 1'b0);
        snn_busy = 1'b0;
        spike_in = 1'b1;
        wr_reg(0, 8'h14, 32'h1, 1'b0);
        #1;
        chk("irq_set_wins", {31'b0, irq[0]}, 32'h1);
        spike_in = 1'b0;
        wr_reg(0, 8'h18, 32'h0, 1'b0);
        wr_reg(0, 8'h14, 32'h1, 1'b0);
        @(posedge clk); #1;
        chk("irq_cleared", {31'b0, irq[0]}, 32'h0);
        rd_reg(0, 8'h0C, 32'h0000_0000, "status_clear", 1'b0);

        // 4-bit counter saturation and soft clear
        wr_reg(2, 8'h00, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        spike_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        spike_in = 1'b0;
        rd_reg(2, 8'h10, 32'h0000_000F, "spike_saturate", 1'b0);
        spike_in = 1'b1;
        wr_reg(2, 8'h00, 32'h0000_0003, 1'b0);
        chk("soft_clr_pulse", {31'b0, snn_soft_clr[2]}, 32'h1);
        @(posedge clk); #1;
        spike_in = 1'b0;
        chk("soft_clr_one_cycle", {31'b0, snn_soft_clr[2]}, 32'h0);
        rd_reg(2, 8'h10, 32'h0, "spike_after_clr", 1'b0);
        rd_reg(2, 8'h00, 32'h0000_0001, "ctrl_bit1_reads0", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/snn_apb_csr.md
Name: snn_apb_csr

Overview:
APB slave control/status register block that sits directly behind the SNN APB bus and consumes the transfers the UVM APB agent drives. Decodes APB reads/writes into SNN core configuration (enable, threshold, leak) and exposes status, a saturating spike counter and a sticky interrupt. Inserts a programmable number of wait states via PREADY.

Parameters:
ADDR_W, 8, decoded paddr width (upper paddr bits ignored)
WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15)
CNT_W, 32, spike counter width (reads zero-extended to 32)
THRESH_RST, 16'h0100, reset value of THRESH

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_W  byte address, word aligned
pwdata  in  32  write data
prdata  out  32  read data, registered
pready  out  1  transfer complete, registered
snn_enable  out  1  CTRL[0]
snn_soft_clr  out  1  one-cycle pulse on write CTRL[1]=1
snn_threshold  out  16  THRESH[15:0]
snn_leak  out  8  LEAK[7:0]
snn_busy  in  1  core busy status
spike_in  in  1  one spike per high cycle
irq  out  1  irq_pending & CTRL[2]

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. Reset: pready=0, prdata=0, CTRL=0, THRESH=THRESH_RST, LEAK=8'h01, SPIKE_CNT=0, LIMIT=0, irq_pending=0, snn_soft_clr=0, FSM=IDLE. Reset mid-transfer aborts it; no write commits.
- Register map (paddr[ADDR_W-1:0]): 0x00 CTRL rw [2:0] (bit1 self-clearing, reads 0); 0x04 THRESH rw [15:0]; 0x08 LEAK rw [7:0]; 0x0C STATUS ro {30'b0, irq_pending, snn_busy}; 0x10 SPIKE_CNT ro; 0x14 IRQ_CLR wo, write bit0=1 clears irq_pending, reads 0; 0x18 LIMIT rw [CNT_W-1:0]. Unimplemented bits read 0. Unmapped addresses: read 0, write ignored.
- FSM IDLE/WAIT/DONE. IDLE: on psel&!penable (setup) latch paddr/pwrite/pwdata; WAIT_STATES==0 -> DONE, else load wait_cnt=WAIT_STATES-1 -> WAIT. WAIT: decrement; at 0 -> DONE. Entering DONE sets pready=1 and loads prdata (reads). DONE: pready high exactly one cycle, write commits on this edge, then IDLE with pready=0, prdata=0.
- Completion latency: access phase lasts WAIT_STATES+1 cycles.
- penable without prior setup is ignored in IDLE (pready stays 0). psel drop mid-WAIT returns FSM to IDLE, no commit.
- Read data sampled at DONE-entry edge (SPIKE_CNT value before that edge's increment).
- SPIKE_CNT: +1 per cycle spike_in=1 while snn_enable=1; saturates at all-ones. Soft clear zeroes it; soft clear wins over same-cycle spike.
- irq_pending sets when LIMIT!=0 and SPIKE_CNT>=LIMIT; sticky until IRQ_CLR. Set and clear in same cycle: set wins.
- snn_soft_clr asserted the cycle after the CTRL write commit, for exactly one cycle.

Optional Feature:
SNN_APB_PSLVERR_EN: adds output pslverr (1 bit), registered, driven high alongside pready when the completing transfer targets an unmapped address or writes a read-only register (0x0C, 0x10); 0 otherwise and at reset. Without the macro the port is absent and such accesses complete silently (reads 0, writes ignored).

Test Plan:
- Reset, read all registers -> CTRL=0, THRESH=0x0100, LEAK=0x01, SPIKE_CNT=0, LIMIT=0, irq=0.
- WAIT_STATES=0: write THRESH=0x1234 then read -> pready high in first access cycle, snn_threshold=0x1234, prdata=0x00001234.
- WAIT_STATES=3: read LEAK -> pready low 3 access cycles, high on 4th for one cycle, then low.
- CTRL=0x5, LIMIT=10, 10 spike_in pulses -> SPIKE_CNT=10, irq=1; write IRQ_CLR=1 with spike_in held high -> irq stays 1 (set wins).
- CNT_W=4: 20 spikes -> SPIKE_CNT=0xF; CTRL write 0x3 same cycle as spike -> snn_soft_clr one-cycle pulse, SPIKE_CNT=0.
- Read 0x3C, write 0x10 -> prdata=0, no state change; with SNN_APB_PSLVERR_EN pslverr=1 on both completions, 0 on mapped accesses.
